// File: rtl/imm_ext_pipe.sv
// Pipelined immediate-extension stage: output register plus one-entry skid buffer.
// Optional jump-target mode is enabled by defining IMM_EXT_JUMP_EN.
module imm_ext_pipe #(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned IMM_W   = 16,
   parameter int unsigned IDX_W   = 26,
   parameter int unsigned OP_W    = 4,
   parameter int unsigned SHAMT_W = $clog2(DATA_W)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [OP_W-1:0]   in_op,
   input  logic [IDX_W-1:0]  in_imm,
   input  logic [DATA_W-1:0] in_pc,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_err
);

   localparam logic [OP_W-1:0] OpZero  = OP_W'(0);
   localparam logic [OP_W-1:0] OpSign  = OP_W'(1);
   localparam logic [OP_W-1:0] OpBr    = OP_W'(2);
   localparam logic [OP_W-1:0] OpHigh  = OP_W'(3);
   localparam logic [OP_W-1:0] OpShamt = OP_W'(4);
`ifdef IMM_EXT_JUMP_EN
   localparam logic [OP_W-1:0] OpJump  = OP_W'(5);
`endif

   logic [IMM_W-1:0]  imm;
   logic [DATA_W-1:0] sext;
   logic [DATA_W-1:0] ext_data;
   logic              ext_err;

   logic              or_valid_q, or_valid_d;
   logic [DATA_W-1:0] or_data_q, or_data_d;
   logic              or_err_q, or_err_d;
   logic              sr_valid_q, sr_valid_d;
   logic [DATA_W-1:0] sr_data_q, sr_data_d;
   logic              sr_err_q, sr_err_d;
   logic              in_ready_q;
   logic              accept;

   assign imm  = in_imm[IMM_W-1:0];
   assign sext = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};

`ifndef IMM_EXT_JUMP_EN
   // Jump disabled: PC and upper index bits have no consumer.
   logic unused_in;
   assign unused_in = ^{in_pc, in_imm[IDX_W-1:IMM_W]};
`endif

   always_comb begin
      ext_data = '0;
      ext_err  = 1'b0;
      unique case (in_op)
         OpZero:  ext_data = {{(DATA_W-IMM_W){1'b0}}, imm};
         OpSign:  ext_data = sext;
         OpBr:    ext_data = sext << 2;
         OpHigh:  ext_data = {imm, {(DATA_W-IMM_W){1'b0}}};
         OpShamt: ext_data = {{(DATA_W-SHAMT_W){1'b0}}, in_imm[6+SHAMT_W-1:6]};
`ifdef IMM_EXT_JUMP_EN
         OpJump:  ext_data = (in_pc & ({DATA_W{1'b1}} << (IDX_W + 2)))
                           | (DATA_W'(in_imm) << 2);
`endif
         default: begin
            ext_data = '0;
            ext_err  = 1'b1;
         end
      endcase
   end

   assign accept = in_valid && in_ready_q;

   always_comb begin
      or_valid_d = or_valid_q;
      or_data_d  = or_data_q;
      or_err_d   = or_err_q;
      sr_valid_d = sr_valid_q;
      sr_data_d  = sr_data_q;
      sr_err_d   = sr_err_q;
      if (flush) begin
         or_valid_d = 1'b0;
         sr_valid_d = 1'b0;
      end else if (!or_valid_q || out_ready) begin
         // SR valid implies in_ready was low, so no input competes with it.
         if (sr_valid_q) begin
            or_valid_d = 1'b1;
            or_data_d  = sr_data_q;
            or_err_d   = sr_err_q;
            sr_valid_d = 1'b0;
         end else begin
            or_valid_d = accept;
            if (accept) begin
               or_data_d = ext_data;
               or_err_d  = ext_err;
            end
         end
      end else if (accept) begin
         sr_valid_d = 1'b1;
         sr_data_d  = ext_data;
         sr_err_d   = ext_err;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         or_valid_q <= 1'b0;
         or_data_q  <= '0;
         or_err_q   <= 1'b0;
         sr_valid_q <= 1'b0;
         sr_data_q  <= '0;
         sr_err_q   <= 1'b0;
         in_ready_q <= 1'b1;
      end else begin
         or_valid_q <= or_valid_d;
         or_data_q  <= or_data_d;
         or_err_q   <= or_err_d;
         sr_valid_q <= sr_valid_d;
         sr_data_q  <= sr_data_d;
         sr_err_q   <= sr_err_d;
         in_ready_q <= !sr_valid_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = or_valid_q;
   assign out_data  = or_data_q;
   assign out_err   = or_err_q;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Self-checking bench for imm_ext_pipe: directed test-plan steps plus randomized traffic
// checked against a queue-based reference model.
module tb_imm_ext_pipe;

   logic        clk = 1'b0;
   logic        reset;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_op;
   logic [25:0] in_imm;
   logic [31:0] in_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        out_err;

   int vectors = 0;
   int miscompares = 0;

   logic [32:0] q[$];  // {err, data} of entries held by the stage, oldest first

   imm_ext_pipe dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_op     (in_op),
      .in_imm    (in_imm),
      .in_pc     (in_pc),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_err   (out_err)
   );

   always #5 clk = ~clk;

   function automatic logic [32:0] ref_result(input int unsigned op, input int unsigned imm,
                                              input int unsigned pc);
      int unsigned i16;
      int unsigned d;
      logic        e;
      i16 = imm % 65536;
      d   = 0;
      e   = 1'b0;
      case (op)
         0: d = i16;
         1: d = (i16 ^ 32'h8000) - 32'h8000;
         2: d = ((i16 ^ 32'h8000) - 32'h8000) * 4;
         3: d = i16 * 65536;
         4: d = (imm / 64) % 32;
`ifdef IMM_EXT_JUMP_EN
         5: d = (pc / 32'h1000_0000) * 32'h1000_0000 + (imm % 32'h0400_0000) * 4;
`endif
         default: begin
            d = 0;
            e = 1'b1;
         end
      endcase
      if (op == 5 && e) d = pc & 0;
      return {e, d};
   endfunction

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Called at posedge+1; applies inputs, checks outputs at negedge, advances model at posedge.
   task automatic step(input logic v, input int unsigned op, input int unsigned imm,
                       input int unsigned pc, input logic ordy, input logic fl);
      logic acc;
      logic dlv;
      in_valid  = v;
      in_op     = op[3:0];
      in_imm    = imm[25:0];
      in_pc     = pc;
      out_ready = ordy;
      flush     = fl;
      @(negedge clk);
      chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
      chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
      if (q.size() != 0) begin
         chk("out_data", 64'(out_data), 64'(q[0][31:0]));
         chk("out_err", 64'(out_err), 64'(q[0][32]));
      end
      acc = v && (q.size() < 2);
      dlv = (q.size() != 0) && ordy;
      @(posedge clk);
      if (fl) begin
         q.delete();
      end else begin
         if (dlv) void'(q.pop_front());
         if (acc) q.push_back(ref_result(op % 16, imm % 32'h0400_0000, pc));
      end
      #1;
   endtask

   initial begin
      reset     = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_op     = '0;
      in_imm    = '0;
      in_pc     = '0;
      out_ready = 1'b1;
      #12;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_data", 64'(out_data), 64'd0);
      chk("rst_out_err", 64'(out_err), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;

      // Back-to-back extensions of 0x8001, one-cycle latency
      step(1'b1, 0, 32'h8001, 0, 1'b1, 1'b0);
      chk("zero", 64'(out_data), 64'h0000_8001);
      step(1'b1, 1, 32'h8001, 0, 1'b1, 1'b0);
      chk("sign", 64'(out_data), 64'hFFFF_8001);
      step(1'b1, 2, 32'h8001, 0, 1'b1, 1'b0);
      chk("br", 64'(out_data), 64'hFFFE_0004);
      step(1'b1, 3, 32'h8001, 0, 1'b1, 1'b0);
      chk("high", 64'(out_data), 64'h8001_0000);
      step(1'b1, 4, 32'h07C0, 0, 1'b1, 1'b0);
      chk("shamt", 64'(out_data), 64'h0000_001F);
      chk("shamt_err", 64'(out_err), 64'd0);
      step(1'b1, 9, $urandom, $urandom, 1'b1, 1'b0);
      chk("illegal_data", 64'(out_data), 64'd0);
      chk("illegal_err", 64'(out_err), 64'd1);
      step(1'b1, 5, 32'h0000_0100, 32'hBFC0_0010, 1'b1, 1'b0);
`ifdef IMM_EXT_JUMP_EN
      chk("jump_data", 64'(out_data), 64'hB000_0400);
      chk("jump_err", 64'(out_err), 64'd0);
`else
      chk("jump_data", 64'(out_data), 64'd0);
      chk("jump_err", 64'(out_err), 64'd1);
`endif
      step(1'b0, 0, 0, 0, 1'b1, 1'b0);
      chk("drained", 64'(out_valid), 64'd0);

      // Back-pressure: A held, B in skid, C refused, then ordered release
      step(1'b1, 0, 32'h1111, 0, 1'b0, 1'b0);
      chk("stall_a", 64'(out_data), 64'h1111);
      chk("stall_rdy_a", 64'(in_ready), 64'd1);
      step(1'b1, 0, 32'h2222, 0, 1'b0, 1'b0);
      chk("stall_hold_a", 64'(out_data), 64'h1111);
      chk("stall_rdy_b", 64'(in_ready), 64'd0);
      step(1'b1, 0, 32'h3333, 0, 1'b0, 1'b0);
      chk("stall_hold_a2", 64'(out_data), 64'h1111);
      step(1'b1, 0, 32'h3333, 0, 1'b1, 1'b0);
      chk("release_b", 64'(out_data), 64'h2222);
      chk("release_rdy", 64'(in_ready), 64'd1);
      step(1'b1, 0, 32'h3333, 0, 1'b1, 1'b0);
      chk("release_c", 64'(out_data), 64'h3333);
      step(1'b0, 0, 0, 0, 1'b1, 1'b0);
      chk("release_empty", 64'(out_valid), 64'd0);

      // Flush with both registers full while D is offered
      step(1'b1, 0, 32'h4444, 0, 1'b0, 1'b0);
      step(1'b1, 0, 32'h5555, 0, 1'b0, 1'b0);
      step(1'b1, 0, 32'h6666, 0, 1'b0, 1'b1);
      chk("flush_valid", 64'(out_valid), 64'd0);
      chk("flush_rdy", 64'(in_ready), 64'd1);
      for (int i = 0; i < 3; i++) step(1'b0, 0, 0, 0, 1'b1, 1'b0);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 3) != 0, $urandom_range(0, 15), $urandom, $urandom,
              $urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0);
      end

      // Asynchronous reset in the middle of a stall
      step(1'b0, 0, 0, 0, 1'b1, 1'b0);
      step(1'b1, 1, 32'h9abc, 0, 1'b0, 1'b0);
      step(1'b1, 3, 32'hdef0, 0, 1'b0, 1'b0);
      in_valid = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      chk("arst_out_valid", 64'(out_valid), 64'd0);
      chk("arst_out_data", 64'(out_data), 64'd0);
      chk("arst_out_err", 64'(out_err), 64'd0);
      chk("arst_in_ready", 64'(in_ready), 64'd1);
      q.delete();
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      step(1'b1, 2, 32'h0001, 0, 1'b1, 1'b0);
      chk("post_reset_br", 64'(out_data), 64'h0000_0004);
      step(1'b0, 0, 0, 0, 1'b1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
